drum_voice: RTL
===============

// Module: drum_voice
// PURPOSE
//  Parametrised percussion voice: a triggered, decaying, pitch-swept sine tone
//  blended with LFSR noise, emitted as offset-binary samples at a divided sample rate.
//  Next-generation tone/noise source for the drummer top level.
//  Drives the GPIO DAC bus directly, or a later mixer that sums several voices.
// PARAMETERS
//  DATA_W      8     sample width; offset-binary out, idle code 2^(DATA_W-1)
//  PHASE_W     16    phase accumulator / phase increment width
//  LUT_AW      5     sine LUT address bits (2^LUT_AW entries, full period)
//  ENV_W       8     envelope amplitude width
//  LFSR_W      16    noise LFSR width
//  SAMPLE_DIV  1134  clk cycles per sample tick (50 MHz / 1134 ~ 44.1 kHz), >=4
// PORTS
//  clk           in   1        system clock (MAX10_CLK1_50 at top level)
//  reset         in   1        synchronous, active-high reset
//  trigger       in   1        strike request; any-cycle pulse, level or edge
//  start_inc     in   PHASE_W  phase increment at strike
//  min_inc       in   PHASE_W  pitch-sweep floor
//  sweep_step    in   PHASE_W  increment decrease per tick
//  decay_rate    in   ENV_W    envelope decrease per tick; 0 = sustain forever
//  noise_mix     in   DATA_W   0 = pure tone ... 2^DATA_W-1 = almost all noise
//  sample_out    out  DATA_W   registered sample
//  sample_valid  out  1        1-clk pulse when sample_out updates
//  busy          out  1        high while state == PLAY
// BEHAVIOUR
//  Reset (sync, priority over all): sample_out=2^(DATA_W-1), sample_valid=0, busy=0,
//   state=IDLE, tick counter=0, env=0, phase=0, inc=0, trig_pend=0, LFSR=seed.
//   Reset mid-PLAY aborts the note; output returns to idle code on the next edge.
//  Tick: counter runs 0..SAMPLE_DIV-1; tick=1 for one clk when count==SAMPLE_DIV-1,
//   then wraps to 0. Ticks occur in IDLE too; sample_valid pulses every tick.
//  trigger high on any clk sets trig_pend. trig_pend is consumed at the next tick.
//   A trigger coincident with that tick is included in it.
//  States IDLE, PLAY. On each tick, in priority order:
//   1. trig_pend -> PLAY: phase=0, inc=start_inc, env=2^ENV_W-1, clear trig_pend.
//      Retriggers in PLAY restart the note the same way. LFSR is never restarted.
//   2. Else if PLAY: phase+=inc (mod 2^PHASE_W); inc=max(inc-sweep_step, min_inc),
//      borrow-safe, so inc holds at min_inc; env=max(env-decay_rate, 0).
//      If new env==0 -> IDLE.
//   3. Else IDLE: nothing changes.
//   The sample emitted for a tick uses the post-update phase/env; a 0 env gives 2^(DATA_W-1).
//  LFSR: Galois, x^16+x^14+x^13+x^11+1, seed 16'hACE1. Steps once per tick; never 0.
//  Arithmetic (signed, width 2*DATA_W+ENV_W+2, no intermediate overflow):
//   tone  = LUT[phase[PHASE_W-1 -: LUT_AW]] - 2^(DATA_W-1)
//   noise = signed(lfsr[DATA_W-1:0])
//   mixed = ((2^DATA_W - noise_mix)*tone + noise_mix*noise) >>> DATA_W
//   scaled = (mixed*env) >>> ENV_W; sample_out = sat(scaled + 2^(DATA_W-1), 0..2^DATA_W-1)
//  Latency: stage 1 registers tone/noise/env on tick+1; stage 2 registers sample_out
//   and sample_valid on tick+2. Updates from back-to-back ticks never overlap (SAMPLE_DIV>=4).
//  Parameter changes take effect only at a strike (start_inc) or per tick (others).
// STRUCTURE
//  Package drum_pkg holds:
//   - typedef enum logic {IDLE, PLAY} voice_state_t
//   - 32-entry 8-bit sine LUT constant (80,98,B0,...,4F,67 hex)
//   - LFSR tap mask and seed constants
//  Sub-module drum_lfsr #(LFSR_W): clk, reset, step, q. Replaces the old 5-bit free-running random.
//  Tick counter, FSM, phase/envelope datapath and 2-stage mix pipeline stay in drum_voice.
// TESTING (bench uses SAMPLE_DIV=4 unless noted)
//  1 Reset, idle 40 clk:
//    -> sample_out==8'h80 throughout, busy=0
//    -> sample_valid every 4th clk, 2 clk after tick
//  2 trigger, start_inc=16'h0800, sweep_step=0, decay_rate=0, noise_mix=0:
//    -> outputs 80,97,AF,C6 hex (LUT*255/256), busy stays 1
//  3 decay_rate=8'hFF, noise_mix=0, trigger:
//    -> first sample env=255, next tick env=0 and out 8'h80
//    -> busy falls at that tick
//  4 start_inc=16'h1000, sweep_step=16'h0100, min_inc=16'h0800:
//    -> inc reaches 16'h0800 after 8 ticks, then holds (no underflow)
//  5 decay_rate=1; retrigger at tick 50; also trigger on the same clk as a tick:
//    -> env back to 255 and phase to 0 at the consuming tick
//    -> the same-clk trigger is consumed by that tick
//  6 reset asserted mid-PLAY:
//    -> next clk sample_out=8'h80, busy=0, LFSR=16'hACE1
//  Also: noise_mix=8'hFF, decay_rate=0 for 2^16 ticks -> LFSR never 0, period 65535.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared types and constants for the drum voice: FSM state, sine table, LFSR taps/seed.
package drum_pkg;

  typedef enum logic {IDLE, PLAY} voice_state_t;

  localparam int SINE_N = 32;

  // One full sine period, offset-binary, floor(128 + 128*sin(2*pi*i/32)) clamped to 8'hFF.
  localparam logic [7:0] SINE_LUT [SINE_N] = '{
    8'h80, 8'h98, 8'hB0, 8'hC7, 8'hDA, 8'hEA, 8'hF6, 8'hFD,
    8'hFF, 8'hFD, 8'hF6, 8'hEA, 8'hDA, 8'hC7, 8'hB0, 8'h98,
    8'h80, 8'h67, 8'h4F, 8'h38, 8'h25, 8'h15, 8'h09, 8'h02,
    8'h00, 8'h02, 8'h09, 8'h15, 8'h25, 8'h38, 8'h4F, 8'h67
  };

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/drum_lfsr.sv
// Galois noise LFSR that advances one position per step pulse; the low OUT_W bits are exported.
module drum_lfsr import drum_pkg::*; #(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = LFSR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  output logic [OUT_W-1:0]  q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);
  localparam logic [LFSR_W-1:0] SEED = LFSR_W'(LFSR_SEED);

  logic [LFSR_W-1:0] state_q, state_d;

  // Next LFSR word: shift right and fold the taps back in when a 1 falls out.
  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    end
  end

  // State register; a non-zero seed keeps the sequence out of the lock-up state.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign q = state_q[OUT_W-1:0];

endmodule

// File: rtl/drum_voice.sv
// Triggered percussion voice: decaying, pitch-swept sine blended with LFSR noise,
// one offset-binary sample per SAMPLE_DIV clocks through a two-stage mix pipeline.
// sample_valid is a one-clock pulse with no ready: the consumer must take sample_out
// in the cycle sample_valid is high; sample_out holds its value between pulses.
module drum_voice import drum_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int PHASE_W    = 16,
  parameter int LUT_AW     = 5,
  parameter int ENV_W      = 8,
  parameter int LFSR_W     = 16,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic [PHASE_W-1:0]  start_inc,
  input  logic [PHASE_W-1:0]  min_inc,
  input  logic [PHASE_W-1:0]  sweep_step,
  input  logic [ENV_W-1:0]    decay_rate,
  input  logic [DATA_W-1:0]   noise_mix,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                busy
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int MW    = 2*DATA_W + ENV_W + 2;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SAMPLE_DIV-1);
  localparam logic signed [MW-1:0] FULL_WT  = MW'(2**DATA_W);
  localparam logic signed [MW-1:0] MID_CODE = MW'(2**(DATA_W-1));
  localparam logic signed [MW-1:0] MAX_CODE = MW'(2**DATA_W-1);
  localparam logic [DATA_W-1:0]    IDLE_OUT = DATA_W'(2**(DATA_W-1));
  localparam logic [DATA_W-1:0]    MSB_FLIP = DATA_W'(2**(DATA_W-1));

  // Tick counter, note FSM and phase/envelope datapath.
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  voice_state_t       state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [ENV_W-1:0]   env_q, env_d;
  logic               trig_pend_q, trig_pend_d;
  logic [DATA_W-1:0]  mix_q, mix_d;
  logic               tick_d1_q, tick_d1_d;
  // Stage 1: tone, noise and envelope captured the clock after a tick.
  logic signed [DATA_W-1:0] tone_q, tone_d;
  logic signed [DATA_W-1:0] noise_q, noise_d;
  logic [ENV_W-1:0]         s1_env_q, s1_env_d;
  logic                     s1_v_q, s1_v_d;
  // Stage 2: final sample register.
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;

  logic               tick;
  logic [DATA_W-1:0]  lfsr_noise;
  logic [LUT_AW-1:0]  lut_idx;
  logic [DATA_W-1:0]  lut_val;
  logic signed [MW-1:0] tone_x, noise_x, wt_noise_x, wt_tone_x, env_x;
  logic signed [MW-1:0] mixed, scaled, level;

  assign tick = (cnt_q == CNT_LAST);

  drum_lfsr #(
    .LFSR_W (LFSR_W),
    .OUT_W  (DATA_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (tick),
    .q     (lfsr_noise)
  );

  // Tick counter, strike latch and per-tick note update (strike beats decay).
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    trig_pend_d = trig_pend_q | trigger;
    state_d     = state_q;
    phase_d     = phase_q;
    inc_d       = inc_q;
    env_d       = env_q;
    mix_d       = mix_q;
    tick_d1_d   = tick;
    if (tick) begin
      trig_pend_d = 1'b0;
      mix_d       = noise_mix;
      if (trig_pend_q || trigger) begin
        state_d = PLAY;
        phase_d = '0;
        inc_d   = start_inc;
        env_d   = '1;
      end else if (state_q == PLAY) begin
        phase_d = phase_q + inc_q;
        // Borrow-safe sweep: never wraps below the floor.
        if ((inc_q >= sweep_step) && ((inc_q - sweep_step) >= min_inc)) begin
          inc_d = inc_q - sweep_step;
        end else begin
          inc_d = min_inc;
        end
        env_d = (env_q > decay_rate) ? (env_q - decay_rate) : '0;
        if (env_d == '0) state_d = IDLE;
      end
    end
  end

  // Stage 1 inputs: LUT lookup on the post-update phase, converted to two's complement.
  always_comb begin
    lut_idx  = phase_q[PHASE_W-1 -: LUT_AW];
    lut_val  = DATA_W'(SINE_LUT[lut_idx]);
    tone_d   = tone_q;
    noise_d  = noise_q;
    s1_env_d = s1_env_q;
    s1_v_d   = tick_d1_q;
    if (tick_d1_q) begin
      tone_d   = lut_val ^ MSB_FLIP;
      noise_d  = lfsr_noise;
      s1_env_d = env_q;
    end
  end

  // Stage 2: crossfade tone/noise, apply envelope, re-centre and saturate.
  always_comb begin
    tone_x     = {{(MW-DATA_W){tone_q[DATA_W-1]}}, tone_q};
    noise_x    = {{(MW-DATA_W){noise_q[DATA_W-1]}}, noise_q};
    wt_noise_x = {{(MW-DATA_W){1'b0}}, mix_q};
    wt_tone_x  = FULL_WT - wt_noise_x;
    env_x      = {{(MW-ENV_W){1'b0}}, s1_env_q};
    mixed      = (wt_tone_x * tone_x + wt_noise_x * noise_x) >>> DATA_W;
    scaled     = (mixed * env_x) >>> ENV_W;
    level      = scaled + MID_CODE;
    sample_d   = sample_q;
    valid_d    = s1_v_q;
    if (s1_v_q) begin
      if (level < 0)             sample_d = '0;
      else if (level > MAX_CODE) sample_d = '1;
      else                       sample_d = level[DATA_W-1:0];
    end
  end

  // All state registers; reset aborts any note and parks the output at the idle code.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      state_q     <= IDLE;
      phase_q     <= '0;
      inc_q       <= '0;
      env_q       <= '0;
      trig_pend_q <= 1'b0;
      mix_q       <= '0;
      tick_d1_q   <= 1'b0;
      tone_q      <= '0;
      noise_q     <= '0;
      s1_env_q    <= '0;
      s1_v_q      <= 1'b0;
      sample_q    <= IDLE_OUT;
      valid_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      inc_q       <= inc_d;
      env_q       <= env_d;
      trig_pend_q <= trig_pend_d;
      mix_q       <= mix_d;
      tick_d1_q   <= tick_d1_d;
      tone_q      <= tone_d;
      noise_q     <= noise_d;
      s1_env_q    <= s1_env_d;
      s1_v_q      <= s1_v_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q == PLAY);

endmodule
